// File: rtl/serv_bus_defs.sv
// Shared definitions for the SERV ibus/dbus arbiter: grant states, the
// merged slave request bundle and the read data returned on a timeout.
package serv_bus_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    localparam logic [31:0] TIMEOUT_RDT = 32'h0;

endpackage

// File: rtl/serv_bus_wdog.sv
// Transaction watchdog: counts unacked cycles of the current grant and flags
// expiry on the limit cycle unless the slave acks in that same cycle.
module serv_bus_wdog #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    input  logic run,
    input  logic ack,
    output logic expire
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (run && !ack)
            cnt <= cnt + 1'b1;
    end

    assign expire = run && !ack && (cnt == {TIMEOUT_W{1'b1}});

endmodule

// File: rtl/serv_bus_arb.sv
// Merges SERV ibus and dbus onto one Wishbone master port. Data bus wins ties,
// grants are held to completion, and a watchdog terminates stalled slaves.
module serv_bus_arb
    import serv_bus_defs::*;
#(
    parameter int TIMEOUT_W    = 8,
    parameter bit WITH_TIMEOUT = 1
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_err_clr,
    output logic        o_err,
    output logic [31:0] o_err_adr
);

    bus_state_e  state;
    wb_req_t     req;
    logic        busy;
    logic        gnt_cyc;
    logic        expire;
    logic [31:0] rdt;

    // Any completion returns to IDLE, which gives the master a cycle to drop cyc.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (i_dbus_cyc)      state <= DBUS;
                         else if (i_ibus_cyc) state <= IBUS;
                IBUS:    if (!i_ibus_cyc || i_wb_ack || expire) state <= IDLE;
                DBUS:    if (!i_dbus_cyc || i_wb_ack || expire) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req     = '0;
        gnt_cyc = 1'b0;
        case (state)
            IBUS: begin
                req.adr = i_ibus_adr;
                req.sel = 4'hF;
                gnt_cyc = i_ibus_cyc;
            end
            DBUS: begin
                req     = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we};
                gnt_cyc = i_dbus_cyc;
            end
            default: ;
        endcase
    end

    assign busy     = (state != IDLE);
    assign o_wb_cyc = busy && !expire;
    assign o_wb_adr = req.adr;
    assign o_wb_dat = req.dat;
    assign o_wb_sel = req.sel;
    assign o_wb_we  = req.we;

    assign o_ibus_ack = (state == IBUS) && (i_wb_ack || expire);
    assign o_dbus_ack = (state == DBUS) && (i_wb_ack || expire);
    assign rdt        = expire ? TIMEOUT_RDT : (busy ? i_wb_rdt : 32'h0);
    assign o_ibus_rdt = rdt;
    assign o_dbus_rdt = rdt;

    generate
        if (WITH_TIMEOUT) begin : g_wdog
            serv_bus_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
                .clk    (clk),
                .i_rst  (i_rst),
                .clr    (!busy),
                .run    (busy && gnt_cyc),
                .ack    (i_wb_ack),
                .expire (expire)
            );

            // A new timeout beats a simultaneous clear and re-captures the address.
            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    o_err     <= 1'b0;
                    o_err_adr <= 32'h0;
                end else if (expire) begin
                    o_err <= 1'b1;
                    if (!o_err || i_err_clr)
                        o_err_adr <= o_wb_adr;
                end else if (i_err_clr) begin
                    o_err <= 1'b0;
                end
            end
        end else begin : g_no_wdog
            assign expire    = 1'b0;
            assign o_err     = 1'b0;
            assign o_err_adr = 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_serv_bus_arb.sv
// Directed plus randomized transactions against a cycle-level model of the
// arbiter built from the grant, ack, watchdog and sticky-error rules.
module tb_serv_bus_arb;

    localparam int TW    = 3;
    localparam int LIMIT = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ibus_adr, o_ibus_rdt;
    logic        i_ibus_cyc, o_ibus_ack;
    logic [31:0] i_dbus_adr, i_dbus_dat, o_dbus_rdt;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we, i_dbus_cyc, o_dbus_ack;
    logic [31:0] o_wb_adr, o_wb_dat, i_wb_rdt;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, i_wb_ack;
    logic        i_err_clr, o_err;
    logic [31:0] o_err_adr;

    int          checks = 0;
    int          errors = 0;
    logic        merr = 1'b0;
    logic [31:0] madr = 32'h0;

    serv_bus_arb #(.TIMEOUT_W(TW), .WITH_TIMEOUT(1)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
        .i_err_clr(i_err_clr), .o_err(o_err), .o_err_adr(o_err_adr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // New request(s) from IDLE; nothing is granted in the request cycle.
    task automatic req(input bit ri, input bit rd, input logic [31:0] iadr,
                       input logic [31:0] dadr, input logic [31:0] ddat,
                       input logic [3:0] dsel, input logic dwe);
        @(posedge clk); #1;
        i_ibus_adr = iadr; i_ibus_cyc = ri;
        i_dbus_adr = dadr; i_dbus_dat = ddat; i_dbus_sel = dsel; i_dbus_we = dwe;
        i_dbus_cyc = rd;
        i_wb_ack   = 1'($urandom_range(0, 1));
        i_err_clr  = 1'b0;
        @(negedge clk);
        chk("grant_latency_cyc", 32'(o_wb_cyc), 32'h0);
        chk("idle_ibus_ack", 32'(o_ibus_ack), 32'h0);
        chk("idle_dbus_ack", 32'(o_dbus_ack), 32'h0);
    endtask

    // One granted transaction: slave acks d cycles after cyc rises (timeout
    // if d exceeds the limit), master optionally abandons at cycle drop.
    task automatic serve(input bit is_d, input int d, input logic [31:0] rdt,
                         input bit clr_exp, input int drop);
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        we;
        bit          done, to, ack, dropped;
        done = 1'b0;
        adr  = is_d ? i_dbus_adr : i_ibus_adr;
        dat  = is_d ? i_dbus_dat : 32'h0;
        sel  = is_d ? i_dbus_sel : 4'hF;
        we   = is_d ? i_dbus_we  : 1'b0;
        for (int k = 0; k <= LIMIT + 1 && !done; k++) begin
            @(posedge clk); #1;
            dropped = (k == drop);
            to      = !dropped && (k == LIMIT) && (k != d);
            ack     = !dropped && ((k == d) || to);
            if (dropped) begin
                if (is_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
            end
            i_wb_ack  = !dropped && (k == d);
            i_wb_rdt  = (k == d) ? rdt : $urandom;
            i_err_clr = clr_exp && to;
            @(negedge clk);
            chk("wb_cyc", 32'(o_wb_cyc), 32'(!to));
            chk("wb_adr", o_wb_adr, adr);
            chk("wb_dat", o_wb_dat, dat);
            chk("wb_sel", 32'(o_wb_sel), 32'(sel));
            chk("wb_we", 32'(o_wb_we), 32'(we));
            chk("ibus_ack", 32'(o_ibus_ack), 32'(!is_d && ack));
            chk("dbus_ack", 32'(o_dbus_ack), 32'(is_d && ack));
            if (ack)
                chk("ack_rdt", is_d ? o_dbus_rdt : o_ibus_rdt, to ? 32'h0 : rdt);
            if (to) begin
                if (!merr || clr_exp) madr = adr;
                merr = 1'b1;
            end
            done = ack || dropped;
        end
        // Turnaround: master drops cyc, a stray slave ack must be ignored.
        @(posedge clk); #1;
        if (is_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
        i_wb_ack  = 1'($urandom_range(0, 1));
        i_wb_rdt  = $urandom;
        i_err_clr = 1'b0;
        @(negedge clk);
        chk("turn_cyc", 32'(o_wb_cyc), 32'h0);
        chk("turn_adr", o_wb_adr, 32'h0);
        chk("turn_ibus_ack", 32'(o_ibus_ack), 32'h0);
        chk("turn_dbus_ack", 32'(o_dbus_ack), 32'h0);
        chk("err", 32'(o_err), 32'(merr));
        chk("err_adr", o_err_adr, madr);
    endtask

    task automatic clr_err();
        @(posedge clk); #1;
        i_err_clr = 1'b1;
        @(posedge clk); #1;
        i_err_clr = 1'b0;
        merr = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(o_err), 32'h0);
        chk("err_adr_kept", o_err_adr, madr);
    endtask

    initial begin
        i_rst = 1'b1;
        i_ibus_adr = '0; i_ibus_cyc = 1'b0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
        i_wb_rdt = '0; i_wb_ack = 1'b0; i_err_clr = 1'b0;
        #3;
        chk("rst_cyc", 32'(o_wb_cyc), 32'h0);
        chk("rst_adr", o_wb_adr, 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_err_adr", o_err_adr, 32'h0);
        #9 i_rst = 1'b0;

        // Plain fetch, ack two cycles after cyc.
        req(1, 0, 32'h0000_1000, '0, '0, '0, 1'b0);
        serve(0, 2, 32'h0000_0013, 1'b0, -1);

        // Simultaneous requests: dbus write first, then ibus after turnaround.
        req(1, 1, 32'h0000_1004, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        serve(1, 1, $urandom, 1'b0, -1);
        serve(0, 0, $urandom, 1'b0, -1);

        // Timeouts: first captures the address, second leaves it.
        req(1, 0, 32'h40, '0, '0, '0, 1'b0);
        serve(0, 99, '0, 1'b0, -1);
        req(1, 0, 32'h80, '0, '0, '0, 1'b0);
        serve(0, 99, '0, 1'b0, -1);
        clr_err();

        // Slave ack exactly on the limit cycle.
        req(0, 1, '0, 32'h44, 32'h1234_5678, 4'hF, 1'b0);
        serve(1, LIMIT, 32'hCAFE_F00D, 1'b0, -1);

        // Clear coinciding with a new timeout while the flag is set.
        req(1, 0, 32'hC0, '0, '0, '0, 1'b0);
        serve(0, 99, '0, 1'b0, -1);
        req(0, 1, '0, 32'hE0, 32'h5, 4'h1, 1'b1);
        serve(1, 99, '0, 1'b1, -1);

        // Master abandons mid-transaction.
        req(1, 0, 32'h2000, '0, '0, '0, 1'b0);
        serve(0, 5, $urandom, 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            int p, d1, d2, dr;
            p  = $urandom_range(0, 2);
            d1 = $urandom_range(0, 9);
            d2 = $urandom_range(0, 9);
            dr = -1;
            if (d1 > 0 && $urandom_range(0, 5) == 0)
                dr = $urandom_range(0, ((d1 > LIMIT) ? LIMIT : d1) - 1);
            req(p != 1, p != 0, $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom));
            if (p != 0) begin
                serve(1, d1, $urandom, 1'($urandom_range(0, 1)), dr);
                if (p == 2) serve(0, d2, $urandom, 1'b0, -1);
            end else begin
                serve(0, d1, $urandom, 1'b0, dr);
            end
            if ($urandom_range(0, 7) == 0) clr_err();
        end

        // Reset while dbus holds the bus.
        req(0, 1, '0, 32'h200, 32'h77, 4'hF, 1'b1);
        @(posedge clk); #1;
        i_wb_ack = 1'b0;
        #2;
        chk("pre_rst_cyc", 32'(o_wb_cyc), 32'h1);
        i_rst = 1'b1;
        #1;
        chk("async_rst_cyc", 32'(o_wb_cyc), 32'h0);
        chk("async_rst_adr", o_wb_adr, 32'h0);
        chk("async_rst_dbus_ack", 32'(o_dbus_ack), 32'h0);
        chk("async_rst_err", 32'(o_err), 32'h0);
        chk("async_rst_err_adr", o_err_adr, 32'h0);
        merr = 1'b0;
        madr = 32'h0;
        i_dbus_cyc = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        req(1, 0, 32'h300, '0, '0, '0, 1'b0);
        serve(0, 1, 32'h0BAD_CAFE, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
